vga_scanout_160x120: RTL and testbench

//  - Read side of the 160x120x12 framebuffer: raster-scans the RAM through its read-only port (RA2/RD2).
//  - Drives 640x480@60 VGA; each framebuffer pixel is shown as a 4x4 block of screen pixels.
//  - Sits between the framebuffer RAM and the board VGA connector; the MCU writes through the other RAM port.

---
 rtl/vga_pkg.sv | 66 ++++++
 rtl/vga_scanout_160x120_if.sv | 33 +++
 rtl/vga_timing_gen.sv | 58 +++++
 rtl/vga_scanout_160x120.sv | 104 ++++++++++
 tb/tb_vga_scanout_160x120.sv | 253 +++++++++++++++++++++++++
 5 files changed

// File: rtl/vga_pkg.sv
// Shared definitions for the 160x120 framebuffer VGA scanout.
// Optional build macro: VGA_TEST_PATTERN_EN (adds the colour-bar test mode).
package vga_pkg;

    // 640x480@60 timing, in 25 MHz pixel clocks and lines
    localparam int H_ACTIVE   = 640;
    localparam int H_FP       = 16;
    localparam int H_SYNC     = 96;
    localparam int H_BP       = 48;
    localparam int V_ACTIVE   = 480;
    localparam int V_FP       = 10;
    localparam int V_SYNC     = 2;
    localparam int V_BP       = 33;
    localparam int H_TOTAL    = H_ACTIVE + H_FP + H_SYNC + H_BP;   // 800
    localparam int V_TOTAL    = V_ACTIVE + V_FP + V_SYNC + V_BP;   // 525
    localparam int HS_START   = H_ACTIVE + H_FP;                   // 656
    localparam int HS_END     = HS_START + H_SYNC - 1;             // 751
    localparam int VS_START   = V_ACTIVE + V_FP;                   // 490
    localparam int VS_END     = VS_START + V_SYNC - 1;             // 491
    localparam int SCALE_LOG2 = 2;                                 // 4x4 pixel replication

    typedef logic [14:0] fb_addr_t;
    typedef logic [11:0] rgb12_t;
    typedef logic [9:0]  hcount_t;
    typedef logic [9:0]  vcount_t;

    // Counter-width copies of the timing constants
    localparam hcount_t H_LAST   = hcount_t'(H_TOTAL - 1);
    localparam vcount_t V_LAST   = vcount_t'(V_TOTAL - 1);
    localparam hcount_t H_ACT_C  = hcount_t'(H_ACTIVE);
    localparam vcount_t V_ACT_C  = vcount_t'(V_ACTIVE);
    localparam hcount_t HS_S_C   = hcount_t'(HS_START);
    localparam hcount_t HS_E_C   = hcount_t'(HS_END);
    localparam vcount_t VS_S_C   = vcount_t'(VS_START);
    localparam vcount_t VS_E_C   = vcount_t'(VS_END);

    // Each test bar is 80 screen pixels = 20 framebuffer columns wide
    localparam int BAR_COLS = 80 >> SCALE_LOG2;

    // Bar number (0..7) for a framebuffer column
    function automatic logic [2:0] bar_index(input logic [7:0] col);
        logic [2:0] idx;
        idx = 3'd0;
        for (int i = 1; i < 8; i++) begin
            if (col >= 8'(i * BAR_COLS)) idx = 3'(i);
        end
        return idx;
    endfunction

    // Colour-bar lookup table
    function automatic rgb12_t bar_color(input logic [2:0] idx);
        rgb12_t c;
        case (idx)
            3'd0:    c = 12'hFFF;
            3'd1:    c = 12'hFF0;
            3'd2:    c = 12'h0FF;
            3'd3:    c = 12'h0F0;
            3'd4:    c = 12'hF0F;
            3'd5:    c = 12'hF00;
            3'd6:    c = 12'h00F;
            default: c = 12'h000;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/vga_scanout_160x120_if.sv
// Framebuffer read port plus VGA pin bundle for the scanout block.
// Optional build macro: VGA_TEST_PATTERN_EN (adds TEST_MODE).
interface vga_scanout_160x120_if;
    import vga_pkg::*;

    fb_addr_t RA2;
    rgb12_t   RD2;
    rgb12_t   VGA_RGB;
    logic     VGA_HS;
    logic     VGA_VS;
    logic     FRAME_START;
`ifdef VGA_TEST_PATTERN_EN
    logic     TEST_MODE;
`endif

    // Scanout side
    modport master (
        output RA2, VGA_RGB, VGA_HS, VGA_VS, FRAME_START,
        input  RD2
`ifdef VGA_TEST_PATTERN_EN
        , input TEST_MODE
`endif
    );

    // RAM / connector side
    modport slave (
        input  RA2, VGA_RGB, VGA_HS, VGA_VS, FRAME_START,
        output RD2
`ifdef VGA_TEST_PATTERN_EN
        , output TEST_MODE
`endif
    );
endinterface

// File: rtl/vga_timing_gen.sv
// Pixel-enable toggle, h/v raster counters and their decodes.
module vga_timing_gen
    import vga_pkg::*;
(
    input  logic       clk_i,
    input  logic       rst_n_i,
    output logic       pix_en_o,
    output logic [7:0] col_o,
    output logic [6:0] row_o,
    output logic       act_o,
    output logic       hs_o,
    output logic       vs_o,
    output logic       frame_start_o
);
    logic    pix_en_q;
    hcount_t h_q, h_d;
    vcount_t v_q, v_d;
    logic    fs_q, fs_d;

    // Counter advance on pixel enables; frame-start flags the clock whose
    // closing edge loads (0,0) into stage 1
    always_comb begin
        h_d = h_q;
        v_d = v_q;
        if (pix_en_q) begin
            if (h_q == H_LAST) begin
                h_d = '0;
                v_d = (v_q == V_LAST) ? '0 : v_q + 10'd1;
            end else begin
                h_d = h_q + 10'd1;
            end
        end
        fs_d = !pix_en_q && (h_q == '0) && (v_q == '0);
    end

    // Toggle, counter and frame-start registers
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            pix_en_q <= 1'b0;
            h_q      <= '0;
            v_q      <= '0;
            fs_q     <= 1'b0;
        end else begin
            pix_en_q <= !pix_en_q;
            h_q      <= h_d;
            v_q      <= v_d;
            fs_q     <= fs_d;
        end
    end

    assign pix_en_o      = pix_en_q;
    assign col_o         = h_q[9:2];
    assign row_o         = v_q[8:2];
    assign act_o         = (h_q < H_ACT_C) && (v_q < V_ACT_C);
    assign hs_o          = !((h_q >= HS_S_C) && (h_q <= HS_E_C));
    assign vs_o          = !((v_q >= VS_S_C) && (v_q <= VS_E_C));
    assign frame_start_o = fs_q;
endmodule

// File: rtl/vga_scanout_160x120.sv
// Raster scanout of the 160x120x12 framebuffer to 640x480@60 VGA.
// Optional build macro: VGA_TEST_PATTERN_EN (TEST_MODE colour bars).
module vga_scanout_160x120
    import vga_pkg::*;
(
    input  logic                   CLK_50MHz,
    input  logic                   RST_N,
    vga_scanout_160x120_if.master  vga
);
    logic       pix_en;
    logic [7:0] col;
    logic [6:0] row;
    logic       act, hs, vs, frame_start;

    vga_timing_gen u_timing (
        .clk_i         (CLK_50MHz),
        .rst_n_i       (RST_N),
        .pix_en_o      (pix_en),
        .col_o         (col),
        .row_o         (row),
        .act_o         (act),
        .hs_o          (hs),
        .vs_o          (vs),
        .frame_start_o (frame_start)
    );

    logic     act1_q, act1_d, hs1_q, hs1_d, vs1_q, vs1_d;
    fb_addr_t ra2_q, ra2_d;
    rgb12_t   rgb_q, rgb_d, pixel;
    logic     hs_q, hs_d, vs_q, vs_d;
`ifdef VGA_TEST_PATTERN_EN
    logic [2:0] bar1_q, bar1_d;

    // Active-video source: test bars or framebuffer data
    always_comb begin
        pixel = vga.TEST_MODE ? bar_color(bar1_q) : vga.RD2;
    end
`else
    // Active-video source: framebuffer data
    always_comb begin
        pixel = vga.RD2;
    end
`endif

    // Stage 1 (address + decode) and stage 2 (pins) advance on pixel enables;
    // the address holds through blanking
    always_comb begin
        act1_d = act1_q;
        hs1_d  = hs1_q;
        vs1_d  = vs1_q;
        ra2_d  = ra2_q;
        rgb_d  = rgb_q;
        hs_d   = hs_q;
        vs_d   = vs_q;
`ifdef VGA_TEST_PATTERN_EN
        bar1_d = bar1_q;
`endif
        if (pix_en) begin
            act1_d = act;
            hs1_d  = hs;
            vs1_d  = vs;
            if (act) ra2_d = {row, col};
`ifdef VGA_TEST_PATTERN_EN
            bar1_d = bar_index(col);
`endif
            rgb_d  = act1_q ? pixel : 12'h000;
            hs_d   = hs1_q;
            vs_d   = vs1_q;
        end
    end

    // Pipeline registers; syncs idle high
    always_ff @(posedge CLK_50MHz or negedge RST_N) begin
        if (!RST_N) begin
            act1_q <= 1'b0;
            hs1_q  <= 1'b1;
            vs1_q  <= 1'b1;
            ra2_q  <= '0;
            rgb_q  <= '0;
            hs_q   <= 1'b1;
            vs_q   <= 1'b1;
`ifdef VGA_TEST_PATTERN_EN
            bar1_q <= '0;
`endif
        end else begin
            act1_q <= act1_d;
            hs1_q  <= hs1_d;
            vs1_q  <= vs1_d;
            ra2_q  <= ra2_d;
            rgb_q  <= rgb_d;
            hs_q   <= hs_d;
            vs_q   <= vs_d;
`ifdef VGA_TEST_PATTERN_EN
            bar1_q <= bar1_d;
`endif
        end
    end

    assign vga.RA2         = ra2_q;
    assign vga.VGA_RGB     = rgb_q;
    assign vga.VGA_HS      = hs_q;
    assign vga.VGA_VS      = vs_q;
    assign vga.FRAME_START = frame_start;
endmodule

// File: tb/tb_vga_scanout_160x120.sv
// Self-checking bench for vga_scanout_160x120: hand-derived vector table,
// randomized RAM contents against a time-based raster model, reset corners.
// Optional build macro: VGA_TEST_PATTERN_EN (colour-bar checks).
module tb_vga_scanout_160x120;
    typedef struct packed {
        logic [14:0] ra2;
        logic [11:0] rgb;
        logic        hs;
        logic        vs;
        logic        fs;
    } pins_t;

    typedef struct {
        int    n;
        pins_t exp;
        string tag;
    } vec_t;

    logic clk;
    logic rst_n;
    bit   tm;
    int   edge_n;
    int   total_cnt;
    int   pass_cnt;
    int   fail_shown;
    logic [11:0] mem [0:32767];
    logic [11:0] bars [0:7] = '{12'hFFF, 12'hFF0, 12'h0FF, 12'h0F0,
                                12'hF0F, 12'hF00, 12'h00F, 12'h000};

    vga_scanout_160x120_if vga_bus ();

    vga_scanout_160x120 dut (
        .CLK_50MHz (clk),
        .RST_N     (rst_n),
        .vga       (vga_bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Framebuffer RAM read port: data one clock after address
    always @(posedge clk) vga_bus.RD2 <= mem[vga_bus.RA2];

`ifdef VGA_TEST_PATTERN_EN
    always_comb vga_bus.TEST_MODE = tm;
`endif

    // Clock edges since the last reset release
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) edge_n <= 0;
        else        edge_n <= edge_n + 1;
    end

    function automatic pins_t mk(input int ra2, input int rgb, input bit hs, input bit vs, input bit fs);
        pins_t p;
        p.ra2 = 15'(ra2);
        p.rgb = 12'(rgb);
        p.hs  = hs;
        p.vs  = vs;
        p.fs  = fs;
        return p;
    endfunction

    function automatic int fb_addr(input int h, input int v);
        return ((v / 4) * 256) + (h / 4);
    endfunction

    // Pins after edge n: pixel p is loaded into stage 1 at pixel-enable edge
    // p+1 (clock edge 2p+2) and reaches the pins one pixel-enable later.
    function automatic pins_t model(input int n);
        pins_t e;
        int k, p, h, v;
        e = mk(0, 0, 1'b1, 1'b1, 1'b0);
        k = n / 2;
        if ((n % 2) == 1) begin
            p = (n - 1) / 2;
            e.fs = ((p % 800) == 0) && (((p / 800) % 525) == 0);
        end
        if (k >= 1) begin
            p = k - 1;
            h = p % 800;
            v = (p / 800) % 525;
            if (v >= 480) begin
                h = 639;
                v = 479;
            end else if (h >= 640) begin
                h = 639;
            end
            e.ra2 = 15'(fb_addr(h, v));
        end
        if (k >= 2) begin
            p = k - 2;
            h = p % 800;
            v = (p / 800) % 525;
            e.hs = !(h >= 656 && h <= 751);
            e.vs = !(v >= 490 && v <= 491);
            if (h < 640 && v < 480)
                e.rgb = tm ? bars[h / 80] : mem[fb_addr(h, v)];
        end
        return e;
    endfunction

    function automatic pins_t sample_pins();
        return {vga_bus.RA2, vga_bus.VGA_RGB, vga_bus.VGA_HS, vga_bus.VGA_VS, vga_bus.FRAME_START};
    endfunction

    task automatic check_pins(input string name, input pins_t act, input pins_t exp);
        total_cnt++;
        if (act === exp) begin
            pass_cnt++;
        end else if (fail_shown < 20) begin
            fail_shown++;
            $display("FAIL %s n=%0d: got ra2=%h rgb=%h hs=%b vs=%b fs=%b, expected ra2=%h rgb=%h hs=%b vs=%b fs=%b",
                     name, edge_n, act.ra2, act.rgb, act.hs, act.vs, act.fs,
                     exp.ra2, exp.rgb, exp.hs, exp.vs, exp.fs);
        end
    endtask

    task automatic check_val(input string name, input logic [11:0] act, input logic [11:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s n=%0d: got %h, expected %h", name, edge_n, act, exp);
    endtask

    // Advance to the falling edge after clock edge n (bounded)
    task automatic wait_n(input int n);
        int guard;
        guard = 0;
        while (edge_n < n && guard < 200000) begin
            @(negedge clk);
            guard++;
        end
        if (edge_n != n) begin
            total_cnt++;
            $display("FAIL wait_n: reached edge %0d, wanted %0d", edge_n, n);
        end
    endtask

    // Compare every falling edge against the model up to edge n_end
    task automatic run_model(input string name, input int n_end);
        int guard;
        guard = 0;
        while (edge_n < n_end && guard < 200000) begin
            @(negedge clk);
            check_pins(name, sample_pins(), model(edge_n));
            guard++;
        end
    endtask

    task automatic fill_mem(input int mode);
        for (int a = 0; a < 32768; a++)
            mem[a] = (mode == 0) ? 12'(a) : (mode == 1) ? 12'($urandom) : 12'hFFF;
    endtask

    task automatic restart(input int mode);
        rst_n = 1'b0;
        fill_mem(mode);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    vec_t vecs[$];

    initial begin
        total_cnt  = 0;
        pass_cnt   = 0;
        fail_shown = 0;
        tm         = 1'b0;
        rst_n      = 1'b0;
        fill_mem(0);

        // Hand-derived vectors, RAM holds mem[a] = a[11:0]
        vecs.push_back('{n: 1,    exp: mk(0,     0,     1, 1, 1), tag: "first_pix_en_fs"});
        vecs.push_back('{n: 2,    exp: mk(0,     0,     1, 1, 0), tag: "fs_one_clock"});
        vecs.push_back('{n: 1280, exp: mk('h09F, 'h09F, 1, 1, 0), tag: "last_active_addr_l0"});
        vecs.push_back('{n: 1282, exp: mk('h09F, 'h09F, 1, 1, 0), tag: "last_active_rgb_l0"});
        vecs.push_back('{n: 1284, exp: mk('h09F, 0,     1, 1, 0), tag: "hblank_rgb"});
        vecs.push_back('{n: 1315, exp: mk('h09F, 0,     1, 1, 0), tag: "hs_before_fall"});
        vecs.push_back('{n: 1316, exp: mk('h09F, 0,     0, 1, 0), tag: "hs_fall"});
        vecs.push_back('{n: 1507, exp: mk('h09F, 0,     0, 1, 0), tag: "hs_last_low"});
        vecs.push_back('{n: 1508, exp: mk('h09F, 0,     1, 1, 0), tag: "hs_rise"});
        vecs.push_back('{n: 1602, exp: mk(0,     0,     1, 1, 0), tag: "line1_addr"});
        vecs.push_back('{n: 2915, exp: mk('h09F, 0,     1, 1, 0), tag: "hs2_before_fall"});
        vecs.push_back('{n: 2916, exp: mk('h09F, 0,     0, 1, 0), tag: "hs2_fall"});
        vecs.push_back('{n: 6403, exp: mk('h100, 0,     1, 1, 0), tag: "line4_odd_edge"});
        for (int j = 0; j < 8; j++)
            vecs.push_back('{n: 6402 + 2 * j,
                             exp: mk('h100 + j / 4, (j == 0) ? 0 : 'h100 + (j - 1) / 4, 1, 1, 0),
                             tag: $sformatf("line4_px%0d", j)});
        vecs.sort(x) with (x.n);

        // Reset held for 5 clocks
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check_pins("reset_hold", sample_pins(), mk(0, 0, 1'b1, 1'b1, 1'b0));
        end
        rst_n = 1'b1;

        foreach (vecs[i]) begin
            wait_n(vecs[i].n);
            check_pins(vecs[i].tag, sample_pins(), vecs[i].exp);
            $display("vec %0d %s n=%0d ra2=%h rgb=%h hs=%b vs=%b fs=%b",
                     i, vecs[i].tag, edge_n, vga_bus.RA2, vga_bus.VGA_RGB,
                     vga_bus.VGA_HS, vga_bus.VGA_VS, vga_bus.FRAME_START);
        end

        // Random framebuffer contents over six lines
        restart(1);
        run_model("random_ram", 9600);
        $display("random_ram scan through edge %0d", edge_n);

        // RD2 forced to FFF: blanking must still read black
        restart(2);
        run_model("blank_fff", 3801);
        $display("blank_fff scan through edge %0d", edge_n);

        // Asynchronous reset mid-line (line 2, h=300), checked before any clock
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check_pins("async_reset_midline", sample_pins(), mk(0, 0, 1'b1, 1'b1, 1'b0));
        @(negedge clk);
        check_pins("reset_after_clock", sample_pins(), mk(0, 0, 1'b1, 1'b1, 1'b0));
        rst_n = 1'b1;
        @(negedge clk);
        check_pins("restart_fs", sample_pins(), mk(0, 0, 1'b1, 1'b1, 1'b1));
        run_model("after_midline_reset", 1700);
        $display("after_midline_reset scan through edge %0d", edge_n);

`ifdef VGA_TEST_PATTERN_EN
        // Colour bars, line 0
        tm = 1'b1;
        restart(0);
        begin
            int          pix [0:6]  = '{0, 79, 80, 159, 480, 560, 639};
            logic [11:0] col [0:6]  = '{12'hFFF, 12'hFFF, 12'hFF0, 12'hFF0, 12'h00F, 12'h000, 12'h000};
            for (int i = 0; i < 7; i++) begin
                wait_n(2 * (pix[i] + 2));
                check_val($sformatf("bar_px%0d", pix[i]), vga_bus.VGA_RGB, col[i]);
                $display("bar px %0d rgb=%h", pix[i], vga_bus.VGA_RGB);
            end
        end
        restart(0);
        run_model("pattern_model", 3300);
        tm = 1'b0;
`endif

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end
endmodule
